// File: rtl/lfsr_sprite_collision.sv
// ============================================================================
// Module   : lfsr_sprite_collision
// Brief    : N hitbox-vs-target rectangle overlap detectors plus a 16-bit
//            free-running Fibonacci LFSR random number source.
//            Macro SPRITE_COLL_REG_EN registers colls_o (one-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_sprite_collision #(
    parameter int N_HITBOXES = 3,
    parameter int X_POS_W    = 10,
    parameter int Y_POS_W    = 10,
    parameter int RND_NUM_W  = 9
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_HITBOXES*X_POS_W-1:0] hb_x_pos_i,
    input  logic [N_HITBOXES*Y_POS_W-1:0] hb_y_pos_i,
    input  logic [N_HITBOXES*X_POS_W-1:0] hb_right_i,
    input  logic [N_HITBOXES*Y_POS_W-1:0] hb_bottom_i,
    input  logic [X_POS_W-1:0]            tg_x_pos_i,
    input  logic [X_POS_W-1:0]            tg_right_i,
    input  logic [Y_POS_W-1:0]            tg_y_pos_i,
    input  logic [Y_POS_W-1:0]            tg_bottom_i,
    output logic [N_HITBOXES-1:0]         colls_o,
    output logic [RND_NUM_W-1:0]          rnd_num_o
);

    localparam logic [15:0] c_SEED = 16'hACE1;

    logic [15:0]           r_lfsr;
    logic                  w_fb;
    logic                  w_tg_valid;
    logic [N_HITBOXES-1:0] w_overlap;

    // Taps 16,14,13,11 of the polynomial map to bits 0,2,3,5 when shifting right
    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= c_SEED;
        end else if (r_lfsr == 16'h0000) begin
            r_lfsr <= c_SEED;
        end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    assign rnd_num_o = r_lfsr[RND_NUM_W-1:0];

    // Degenerate rectangles would otherwise satisfy the edge test when inverted
    assign w_tg_valid = (tg_right_i > tg_x_pos_i) && (tg_bottom_i > tg_y_pos_i);

    generate
        for (genvar k = 0; k < N_HITBOXES; k++) begin : g_det
            logic [X_POS_W-1:0] w_hx;
            logic [X_POS_W-1:0] w_hr;
            logic [Y_POS_W-1:0] w_hy;
            logic [Y_POS_W-1:0] w_hb;

            assign w_hx = hb_x_pos_i[k*X_POS_W +: X_POS_W];
            assign w_hr = hb_right_i[k*X_POS_W +: X_POS_W];
            assign w_hy = hb_y_pos_i[k*Y_POS_W +: Y_POS_W];
            assign w_hb = hb_bottom_i[k*Y_POS_W +: Y_POS_W];

            assign w_overlap[k] = w_tg_valid
                                && (w_hr > w_hx) && (w_hb > w_hy)
                                && (w_hx < tg_right_i) && (w_hr > tg_x_pos_i)
                                && (w_hy < tg_bottom_i) && (w_hb > tg_y_pos_i);
        end
    endgenerate

`ifdef SPRITE_COLL_REG_EN
    logic [N_HITBOXES-1:0] r_colls;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_colls <= '0;
        end else begin
            r_colls <= w_overlap;
        end
    end

    assign colls_o = r_colls;
`else
    assign colls_o = w_overlap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_sprite_collision.sv
// Self-checking bench for lfsr_sprite_collision: directed and random overlap
// cases against an interval-intersection model, plus LFSR sequence/period.
`default_nettype none

module tb_lfsr_sprite_collision;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] hb_x = '0, hb_y = '0, hb_r = '0, hb_b = '0;
    logic [9:0]  tg_x = '0, tg_y = '0, tg_r = '0, tg_b = '0;
    logic [2:0]  colls;
    logic [8:0]  rnd;

    int checks = 0;
    int errors = 0;

    lfsr_sprite_collision #(
        .N_HITBOXES(3), .X_POS_W(10), .Y_POS_W(10), .RND_NUM_W(9)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .hb_x_pos_i (hb_x),
        .hb_y_pos_i (hb_y),
        .hb_right_i (hb_r),
        .hb_bottom_i(hb_b),
        .tg_x_pos_i (tg_x),
        .tg_right_i (tg_r),
        .tg_y_pos_i (tg_y),
        .tg_bottom_i(tg_b),
        .colls_o    (colls),
        .rnd_num_o  (rnd)
    );

    always #5 clk = ~clk;

    // Reference LFSR step written as integer arithmetic on the polynomial taps
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int v, fb;
        v = int'(s);
        if (v == 0) return 16'hACE1;
        fb = ((v) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) + (fb << 15));
    endfunction

    // Two rectangles overlap iff the intersection of both axis intervals is non-empty
    function automatic bit intervals_meet(input int a_lo, a_hi, b_lo, b_hi);
        int lo, hi;
        lo = (a_lo > b_lo) ? a_lo : b_lo;
        hi = (a_hi < b_hi) ? a_hi : b_hi;
        return lo < hi;
    endfunction

    function automatic logic [2:0] model_colls();
        logic [2:0] m;
        for (int k = 0; k < 3; k++) begin
            m[k] = intervals_meet(int'(hb_x[k*10 +: 10]), int'(hb_r[k*10 +: 10]),
                                  int'(tg_x), int'(tg_r))
                && intervals_meet(int'(hb_y[k*10 +: 10]), int'(hb_b[k*10 +: 10]),
                                  int'(tg_y), int'(tg_b));
        end
        return m;
    endfunction

    task automatic set_hb(input int k, input int x, input int y, input int r, input int b);
        hb_x[k*10 +: 10] = 10'(x);
        hb_y[k*10 +: 10] = 10'(y);
        hb_r[k*10 +: 10] = 10'(r);
        hb_b[k*10 +: 10] = 10'(b);
    endtask

    task automatic set_tg(input int x, input int y, input int r, input int b);
        tg_x = 10'(x); tg_y = 10'(y); tg_r = 10'(r); tg_b = 10'(b);
    endtask

    // Inputs change at negedge; after the next posedge both configs show the result
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rnd !== 9'h0E1) begin
            errors++;
            $display("FAIL reset_rnd: got %h expected %h", rnd, 9'h0E1);
        end
        checks++;
        if (colls !== 3'b000) begin
            errors++;
            $display("FAIL reset_colls: got %b expected %b", colls, 3'b000);
        end
    endtask

    task automatic test_lfsr_sequence();
        logic [8:0] exp_seq [3];
        exp_seq[0] = 9'h0E1; exp_seq[1] = 9'h070; exp_seq[2] = 9'h138;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rnd !== exp_seq[i]) begin
                errors++;
                $display("FAIL lfsr_seq[%0d]: got %h expected %h", i, rnd, exp_seq[i]);
            end
            settle();
        end
    endtask

    task automatic test_lfsr_period();
        logic [15:0] s;
        int          bad, first_bad;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        s = 16'hACE1;
        bad = 0;
        first_bad = -1;
        for (int c = 1; c <= 65535; c++) begin
            settle();
            s = lfsr_step(s);
            if (rnd !== s[8:0]) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL lfsr_run: %0d cycles differ from model (first at cycle %0d), required 0",
                     bad, first_bad);
        end
        checks++;
        if (rnd !== 9'h0E1) begin
            errors++;
            $display("FAIL lfsr_period: after 65535 cycles got %h expected %h", rnd, 9'h0E1);
        end
    endtask

    task automatic test_directed_overlap();
        @(negedge clk);
        set_hb(0, 10, 10, 18, 50);
        set_hb(1, 10, 10, 18, 11);
        set_hb(2, 100, 100, 120, 120);
        set_tg(15, 20, 19, 24);
`ifndef SPRITE_COLL_REG_EN
        #1;
        checks++;
        if (colls[0] !== 1'b1) begin
            errors++;
            $display("FAIL hb0_comb_same_cycle: got %b expected 1", colls[0]);
        end
`endif
        settle();
        checks++;
        if (colls[0] !== 1'b1) begin
            errors++;
            $display("FAIL hb0_overlap: got %b expected 1", colls[0]);
        end
        // Target shares hitbox 1's right edge only
        @(negedge clk);
        set_tg(18, 10, 22, 14);
        settle();
        checks++;
        if (colls[1] !== 1'b0) begin
            errors++;
            $display("FAIL hb1_edge_touch: got %b expected 0", colls[1]);
        end
        @(negedge clk);
        set_tg(17, 10, 22, 14);
        settle();
        checks++;
        if (colls[1] !== 1'b1) begin
            errors++;
            $display("FAIL hb1_overlap: got %b expected 1", colls[1]);
        end
        // Zero-width hitbox sitting inside the target
        @(negedge clk);
        set_hb(2, 30, 30, 30, 40);
        set_tg(20, 20, 60, 60);
        settle();
        checks++;
        if (colls[2] !== 1'b0) begin
            errors++;
            $display("FAIL degenerate_hb: got %b expected 0", colls[2]);
        end
        checks++;
        if (colls !== model_colls()) begin
            errors++;
            $display("FAIL directed_vector: got %b expected %b", colls, model_colls());
        end
    endtask

    task automatic test_random_overlap();
        int x, y, r, b;
        int bad;
        logic [2:0] exp_c;
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                x = $urandom_range(0, 40);
                y = $urandom_range(0, 40);
                r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, x) : x + $urandom_range(1, 15);
                b = ($urandom_range(0, 7) == 0) ? $urandom_range(0, y) : y + $urandom_range(1, 15);
                if (k < 3) set_hb(k, x, y, r, b);
                else       set_tg(x, y, r, b);
            end
            exp_c = model_colls();
            settle();
            checks++;
            if (colls !== exp_c) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_colls[%0d]: got %b expected %b", n, colls, exp_c);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] exp_c;
        @(negedge clk);
        set_hb(0, 0, 0, 20, 20);
        set_hb(1, 5, 5, 25, 25);
        set_hb(2, 12, 12, 40, 40);
        set_tg(10, 10, 15, 15);
        settle();
        checks++;
        if (colls !== 3'b111) begin
            errors++;
            $display("FAIL all_three: got %b expected %b", colls, 3'b111);
        end
        #2;
        rst_n = 1'b0;
        #1;
`ifdef SPRITE_COLL_REG_EN
        exp_c = 3'b000;
`else
        exp_c = 3'b111;
`endif
        checks++;
        if (colls !== exp_c) begin
            errors++;
            $display("FAIL async_rst_colls: got %b expected %b", colls, exp_c);
        end
        checks++;
        if (rnd !== 9'h0E1) begin
            errors++;
            $display("FAIL async_rst_rnd: got %h expected %h", rnd, 9'h0E1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        checks++;
        if (rnd !== 9'h070) begin
            errors++;
            $display("FAIL restart_rnd: got %h expected %h", rnd, 9'h070);
        end
        checks++;
        if (colls !== 3'b111) begin
            errors++;
            $display("FAIL restart_colls: got %b expected %b", colls, 3'b111);
        end
    endtask

    initial begin
        test_reset();
        test_lfsr_sequence();
        test_directed_overlap();
        test_random_overlap();
        test_async_reset();
        test_lfsr_period();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lfsr_sprite_collision.md
LFSR_SPRITE_COLLISION -- requirements
Module: lfsr_sprite_collision

Interface
- REQ-001 The block SHALL have parameter N_HITBOXES, default 3, meaning the number of independent hitbox-vs-target collision detectors.
- REQ-002 The block SHALL have parameter X_POS_W, default 10, meaning the horizontal coordinate width.
- REQ-003 The block SHALL have parameter Y_POS_W, default 10, meaning the vertical coordinate width.
- REQ-004 The block SHALL have parameter RND_NUM_W, default 9 (range 1..16), meaning the random output width.
- REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
- REQ-006 The block SHALL have port rst_ni, input, 1 bit, the reset: asynchronous, active-low.
- REQ-007 The block SHALL have port hb_x_pos_i, input, N_HITBOXES*X_POS_W bits, the hitbox left edges; hitbox k occupies slice k.
- REQ-008 The block SHALL have port hb_y_pos_i, input, N_HITBOXES*Y_POS_W bits, the hitbox top edges.
- REQ-009 The block SHALL have port hb_right_i, input, N_HITBOXES*X_POS_W bits, the hitbox right edges (exclusive).
- REQ-010 The block SHALL have port hb_bottom_i, input, N_HITBOXES*Y_POS_W bits, the hitbox bottom edges (exclusive).
- REQ-011 The block SHALL have ports tg_x_pos_i / tg_right_i (input, X_POS_W bits each) and tg_y_pos_i / tg_bottom_i (input, Y_POS_W bits each), the target (ball) rectangle shared by all detectors.
- REQ-012 The block SHALL have port colls_o, output, N_HITBOXES bits, where bit k flags that hitbox k overlaps the target.
- REQ-013 The block SHALL have port rnd_num_o, output, RND_NUM_W bits, the pseudo-random number.

Function
- REQ-014 Overlap k SHALL be true iff (hb_x_pos < tg_right) AND (hb_right > tg_x_pos) AND (hb_y_pos < tg_bottom) AND (hb_bottom > tg_y_pos).
- REQ-015 All comparisons SHALL be unsigned; rectangles sharing only an edge (e.g. hb_right == tg_x_pos) SHALL NOT collide.
- REQ-016 A degenerate rectangle (right <= x_pos or bottom <= y_pos) SHALL never collide.
- REQ-017 Each detector SHALL be independent; any combination of colls_o bits MAY be set simultaneously.
- REQ-018 The LFSR SHALL be a 16-bit Fibonacci register, polynomial x^16+x^14+x^13+x^11+1, right-shifting once every clock (free-running).
- REQ-019 The LFSR feedback bit SHALL be s[0]^s[2]^s[3]^s[5], and the next state SHALL be {fb, s[15:1]}.
- REQ-020 The LFSR SHALL have period 65535.
- REQ-021 If the LFSR state is ever all-zero, the next state SHALL be the seed 16'hACE1.
- REQ-022 rnd_num_o SHALL equal s[RND_NUM_W-1:0], driven directly from the state register.

Reset
- REQ-023 Assertion of rst_ni SHALL immediately force colls_o to all-zero and the LFSR state to 16'hACE1, so that rnd_num_o = 9'h0E1 at the default width.
- REQ-024 Reset asserted mid-sequence SHALL restart the LFSR sequence from the seed, with no dependence on prior state.
- REQ-025 The first LFSR advance SHALL occur on the first rising clk_i edge with rst_ni high.

Configuration
- REQ-026 Macro SPRITE_COLL_REG_EN SHALL select the colls_o timing.
- REQ-027 With SPRITE_COLL_REG_EN defined, colls_o SHALL be registered: one-cycle latency from inputs, cleared by reset.
- REQ-028 With SPRITE_COLL_REG_EN undefined, colls_o SHALL be combinational from the current inputs (zero latency, not affected by reset).
- REQ-029 The LFSR behaviour SHALL be identical in both configurations.

Verification
- REQ-030 Release reset, then clock -> rnd_num_o sequence SHALL be 0x0E1, 0x070, 0x138 (states ACE1, 5670, AB38).
- REQ-031 Free-run 65535 cycles after reset -> state SHALL return to ACE1 and SHALL never be zero in between.
- REQ-032 Hitbox 0 = (10,10,18,50), target = (15,20,19,24) -> colls_o[0]=1, one cycle later when SPRITE_COLL_REG_EN is defined, same cycle otherwise.
- REQ-033 Hitbox 1 = (10,10,18,11), target = (18,10,22,14) (edge touch) -> colls_o[1]=0; moving the target to x_pos 17 -> colls_o[1]=1.
- REQ-034 All three hitboxes overlapping the target -> colls_o=3'b111; assert rst_ni low asynchronously mid-cycle (registered config) -> colls_o=0 and rnd_num_o=0x0E1 immediately.
- REQ-035 Degenerate hitbox (right == x_pos) fully inside the target -> colls_o bit SHALL be 0.
